bus_hold_tx: RTL
================

Name: bus_hold_tx

Overview:
- Transmit side of the stable-capture bus synchronizer; runs in the dest_clk domain and drives a quasi-static multi-bit bus back toward another clock domain.
- That domain captures the bus with a stable-for-3-samples receiver.
- The block registers each new word and holds it glitch-free for at least HOLD_CYCLES dest_clk cycles, so the far-end receiver always sees a consistent, stable value.
- Upstream logic writes words with a valid/ready handshake.

Parameters:
- BUS_BW, 8, width of the transported bus.
- HOLD_CYCLES, 6, minimum dest_clk cycles bus_out stays constant after a change. Must be >= 2. Sizing rule: HOLD_CYCLES*T_dest >= 5*T_rx plus margin.
- CNT_W, 8, width of the update counter.

Ports:
- dest_clk  input  1  clock
- dest_rstn  input  1  reset, asynchronous, active-low
- wr_valid  input  1  write request
- wr_ready  output  1  block can accept wr_data this cycle
- wr_data  input  BUS_BW  word to transmit
- bus_out  output  BUS_BW  registered bus to the other domain; driven directly from a flop, no logic after the flop
- busy  output  1  high while in HOLD
- upd_cnt  output  CNT_W  count of words that changed bus_out; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any time, including mid-HOLD):
  - bus_out=0, state=IDLE, hold counter=0, upd_cnt=0, busy=0.
  - Pending entry cleared (shadow build).
  - wr_ready=1 once reset is deasserted.
- States:
  - IDLE: bus free.
  - HOLD: bus_out frozen; counter cnt (width clog2(HOLD_CYCLES)) counts down.
- Launch point: an edge where state==IDLE, or state==HOLD and cnt==0.
- Candidate at a launch point: the accepted wr_data (wr_valid && wr_ready). Shadow build: the pending entry first, if valid.
- Launch rules:
  - If candidate != bus_out: bus_out<=candidate, state<=HOLD, cnt<=HOLD_CYCLES-1, upd_cnt+=1.
  - If candidate == bus_out: word consumed, bus_out unchanged, upd_cnt unchanged. State goes (or stays) IDLE.
  - No candidate at a launch point in HOLD: state<=IDLE.
- In HOLD with cnt!=0: cnt decrements by 1 each cycle; bus_out never changes.
- Result: consecutive bus_out changes are at least HOLD_CYCLES edges apart. Back-to-back writes are spaced exactly HOLD_CYCLES edges apart.
- wr_ready (base build) = IDLE || (HOLD && cnt==0). Derived from flops only; no dependency on wr_valid.
- busy = (state==HOLD).
- Latency: accepted word appears on bus_out at the accepting edge, i.e. the flop output one edge after wr_valid is sampled.
- wr_data is ignored when wr_valid=0. Asserting wr_valid while wr_ready=0 has no effect; upstream holds the word.

Optional Feature:
- Macro BUS_HOLD_TX_SHADOW_EN adds a one-entry pending register (pend_vld, pend_data).
- With the macro:
  - wr_ready = !pend_vld.
  - A word accepted in HOLD with cnt!=0 is written to pend and sets pend_vld.
  - At a launch point, pend has priority over wr_data and is consumed (pend_vld<=0). The same edge may also accept wr_data, because wr_ready was high only if pend was empty; in that case wr_data is launched directly.
  - pend_vld is never 1 while in IDLE.
- Without the macro: no pend logic; base wr_ready rule applies.
- Port list is identical in both builds.

Decomposition:
- Package bus_sync_pkg holds:
  - state encoding constants (IDLE=0, HOLD=1);
  - a clog2 function for the counter width;
  - the default HOLD_CYCLES constant shared with the receive-side sizing.
- Single module; no sub-module needed. Shadow logic stays inline under the macro.

Test Plan (HOLD_CYCLES=6, BUS_BW=8):
- Reset asserted, then released: bus_out=0x00, wr_ready=1, busy=0, upd_cnt=0.
- Write 0xA5 at edge k:
  - bus_out=0xA5 after k, busy=1;
  - wr_ready low after edges k..k+4, high after edge k+5;
  - upd_cnt=1.
- Write 0x00 while bus_out=0x00: accepted in one cycle, busy stays 0, upd_cnt stays 0.
- Base build, wr_valid held with 0x11 then 0x22 then 0x33: bus_out changes at edges k, k+6, k+12; upd_cnt=3.
- Shadow build: 0x11 at k, 0x22 at k+2, 0x33 offered from k+3:
  - 0x22 goes to pend; wr_ready low until k+6;
  - bus_out=0x22 at k+6; 0x33 accepted to pend at k+7; bus_out=0x33 at k+12.
- dest_rstn pulsed low at k+3 during HOLD with pend valid: bus_out=0 immediately, busy=0, pend cleared, upd_cnt=0.

Source files
------------

// File: rtl/bus_sync_pkg.sv
// rtl/bus_sync_pkg.sv - shared constants and helpers for the stable-capture bus synchronizer
package bus_sync_pkg;

  // Transmit-side hold state; the encoding is shared with the receive side.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } bus_state_t;

  // Default minimum hold, sized so HOLD_CYCLES*T_dest covers 5*T_rx plus margin.
  localparam int HOLD_CYCLES_DEFAULT = 6;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int bus_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_hold_tx.sv
// rtl/bus_hold_tx.sv - holds each written word glitch-free on bus_out for HOLD_CYCLES; BUS_HOLD_TX_SHADOW_EN adds a one-entry pending register
module bus_hold_tx
  import bus_sync_pkg::*;
#(
  parameter int BUS_BW      = 8,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int CNT_W       = 8
) (
  input  logic              dest_clk,
  input  logic              dest_rstn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BUS_BW-1:0] wr_data,
  output logic [BUS_BW-1:0] bus_out,
  output logic              busy,
  output logic [CNT_W-1:0]  upd_cnt
);

  localparam int              HC_W      = bus_clog2(HOLD_CYCLES);
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  bus_state_t        state;
  logic [HC_W-1:0]   cnt;
  logic              launch_pt;
  logic              accept;
  logic              cand_vld;
  logic [BUS_BW-1:0] cand_data;

  // The bus may take a new value when idle or on the last cycle of a hold.
  assign launch_pt = (state == ST_IDLE) || (cnt == '0);
  assign accept    = wr_valid && wr_ready;

`ifdef BUS_HOLD_TX_SHADOW_EN
  logic              pend_vld;
  logic [BUS_BW-1:0] pend_data;

  // With a free pending slot the writer never has to wait for the hold to expire.
  assign wr_ready  = !pend_vld;
  assign cand_vld  = pend_vld || accept;
  assign cand_data = pend_vld ? pend_data : wr_data;

  // Park a word written mid-hold; drain it at the next launch point.
  always_ff @(posedge dest_clk or negedge dest_rstn) begin
    if (!dest_rstn) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else if (launch_pt) begin
      pend_vld  <= 1'b0;
    end else if (accept) begin
      pend_vld  <= 1'b1;
      pend_data <= wr_data;
    end
  end
`else
  // Without a pending slot only a launch point can take a word.
  assign wr_ready  = launch_pt;
  assign cand_vld  = accept;
  assign cand_data = wr_data;
`endif

  // Hold FSM: launch differing words, consume equal ones, count down the hold.
  always_ff @(posedge dest_clk or negedge dest_rstn) begin
    if (!dest_rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bus_out <= '0;
      busy    <= 1'b0;
      upd_cnt <= '0;
    end else if (launch_pt) begin
      if (cand_vld && (cand_data != bus_out)) begin
        bus_out <= cand_data;
        state   <= ST_HOLD;
        busy    <= 1'b1;
        cnt     <= HOLD_LOAD;
        upd_cnt <= upd_cnt + CNT_W'(1);
      end else begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
      end
    end else begin
      cnt <= cnt - HC_W'(1);
    end
  end

endmodule
